// File: rtl/golden_nonce_arbiter.sv
// Collects per-core golden-nonce strobes into one slot per core and round-robins them onto a valid/ready stream.
// Latency: match edge k -> pending after k -> out_valid after k+1; holds out_* while out_ready is low, full slots drop and count.
module golden_nonce_arbiter #(
  parameter int NCORES     = 8,
  parameter int NONCE_W    = 32,
  parameter int CORE_W     = $clog2(NCORES),
  parameter int DROP_CNT_W = 16
) (
  input  logic                      hash_clk,
  input  logic                      reset,
  input  logic [NCORES-1:0]         core_match,
  input  logic [NCORES*NONCE_W-1:0] core_nonce,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NONCE_W-1:0]        out_nonce,
  output logic [CORE_W-1:0]         out_core,
  output logic [NCORES-1:0]         pending,
  output logic [DROP_CNT_W-1:0]     drop_count
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  localparam int                   SUM_W     = DROP_CNT_W + CORE_W + 2;
  localparam logic [CORE_W:0]      NCORES_C  = (CORE_W+1)'(NCORES);
  localparam logic [CORE_W-1:0]    LAST_CORE = CORE_W'(NCORES - 1);
  localparam logic [DROP_CNT_W-1:0] DROP_MAX = '1;

  state_t               state;
  logic [NONCE_W-1:0]   slot_nonce [NCORES];
  logic [CORE_W-1:0]    rr_ptr;

  logic                 load;
  logic                 grant_vld;
  logic [CORE_W-1:0]    grant_idx;
  logic [NCORES-1:0]    grant_mask;
  logic [NCORES-1:0]    drop_mask;
  logic [SUM_W-1:0]     drop_sum;
  logic [DROP_CNT_W-1:0] drop_next;

  // The output register may be (re)loaded when empty or when its report is taken.
  assign load = (state == IDLE) || out_ready;

  always_comb begin
    logic [CORE_W:0] idx;
    grant_vld = 1'b0;
    grant_idx = '0;
    idx       = '0;
    for (int k = 0; k < NCORES; k++) begin
      idx = {1'b0, rr_ptr} + (CORE_W+1)'(k);
      if (idx >= NCORES_C) idx = idx - NCORES_C;
      if (!grant_vld && pending[idx[CORE_W-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = idx[CORE_W-1:0];
      end
    end
  end

  always_comb begin
    grant_mask = '0;
    if (load && grant_vld) grant_mask[grant_idx] = 1'b1;
  end

  // A slot being emptied by this cycle's grant can take a new report without loss.
  assign drop_mask = core_match & pending & ~grant_mask;

  always_comb begin
    drop_sum = SUM_W'(drop_count);
    for (int i = 0; i < NCORES; i++) drop_sum = drop_sum + SUM_W'(drop_mask[i]);
    drop_next = (drop_sum > SUM_W'(DROP_MAX)) ? DROP_MAX : drop_sum[DROP_CNT_W-1:0];
  end

  always_ff @(posedge hash_clk) begin
    if (reset) begin
      state      <= IDLE;
      out_valid  <= 1'b0;
      out_nonce  <= '0;
      out_core   <= '0;
      pending    <= '0;
      drop_count <= '0;
      rr_ptr     <= '0;
      for (int i = 0; i < NCORES; i++) slot_nonce[i] <= '0;
    end else begin
      if (load) begin
        if (grant_vld) begin
          state     <= HOLD;
          out_valid <= 1'b1;
          out_nonce <= slot_nonce[grant_idx];
          out_core  <= grant_idx;
          rr_ptr    <= (grant_idx == LAST_CORE) ? '0 : grant_idx + 1'b1;
        end else begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      end
      for (int i = 0; i < NCORES; i++) begin
        if (core_match[i] && (!pending[i] || grant_mask[i]))
          slot_nonce[i] <= core_nonce[i*NONCE_W +: NONCE_W];
      end
      pending    <= (pending & ~grant_mask) | core_match;
      drop_count <= drop_next;
    end
  end

endmodule

// File: tb/tb_golden_nonce_arbiter.sv
// Randomized and directed stimulus against a transaction-level reference model; a monitor scoreboards the report stream.
module tb_golden_nonce_arbiter;

  localparam int N = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    core_match;
  logic [N*32-1:0] core_nonce;
  logic            out_ready;

  logic            out_valid;
  logic [31:0]     out_nonce;
  logic [2:0]      out_core;
  logic [N-1:0]    pending;
  logic [15:0]     drop_count;

  logic            s_out_valid;
  logic [31:0]     s_out_nonce;
  logic [2:0]      s_out_core;
  logic [N-1:0]    s_pending;
  logic [1:0]      s_drop_count;

  golden_nonce_arbiter #(.NCORES(N), .NONCE_W(32), .CORE_W(3), .DROP_CNT_W(16)) dut (
    .hash_clk(clk), .reset(reset), .core_match(core_match), .core_nonce(core_nonce),
    .out_valid(out_valid), .out_ready(out_ready), .out_nonce(out_nonce), .out_core(out_core),
    .pending(pending), .drop_count(drop_count)
  );

  golden_nonce_arbiter #(.NCORES(N), .NONCE_W(32), .CORE_W(3), .DROP_CNT_W(2)) dut_sat (
    .hash_clk(clk), .reset(reset), .core_match(core_match), .core_nonce(core_nonce),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_nonce(s_out_nonce), .out_core(s_out_core),
    .pending(s_pending), .drop_count(s_drop_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: one held report per core, a registered output, and a rotation pointer.
  logic [N-1:0] m_pend = '0;
  logic [31:0]  m_val [N];
  logic         m_vld = 1'b0;
  int           m_ptr = 0;
  longint       m_drops = 0;
  int           exp_core_q [$];
  logic [31:0]  exp_nonce_q [$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int  g;
    bit  take_new;
    if (reset) begin
      m_pend = '0; m_vld = 1'b0; m_ptr = 0; m_drops = 0;
      exp_core_q.delete(); exp_nonce_q.delete();
      return;
    end
    take_new = !m_vld || out_ready;
    g = -1;
    if (take_new) begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (g < 0 && m_pend[c]) g = c;
      end
    end
    if (g >= 0) begin
      exp_core_q.push_back(g);
      exp_nonce_q.push_back(m_val[g]);
      m_pend[g] = 1'b0;
      m_ptr = (g + 1) % N;
      m_vld = 1'b1;
    end else if (take_new) begin
      m_vld = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      if (core_match[i]) begin
        if (!m_pend[i]) begin
          m_pend[i] = 1'b1;
          m_val[i]  = core_nonce[i*32 +: 32];
        end else begin
          m_drops++;
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Monitor: state flags every cycle, report contents whenever out_valid is up.
  initial forever begin
    @(negedge clk);
    chk("out_valid", 64'(out_valid), 64'(m_vld));
    chk("pending", 64'(pending), 64'(m_pend));
    chk("drop_count", 64'(drop_count), (m_drops > 65535) ? 64'd65535 : 64'(m_drops));
    chk("drop_count_sat2", 64'(s_drop_count), (m_drops > 3) ? 64'd3 : 64'(m_drops));
    if (out_valid) begin
      if (exp_core_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_report: got core %0d nonce %0h expected none at %0t", out_core, out_nonce, $time);
      end else begin
        chk("out_core", 64'(out_core), 64'(exp_core_q[0]));
        chk("out_nonce", 64'(out_nonce), 64'(exp_nonce_q[0]));
        if (out_ready) begin
          void'(exp_core_q.pop_front());
          void'(exp_nonce_q.pop_front());
        end
      end
    end
  end

  task automatic step(input logic [N-1:0] m, input logic rdy, input logic rst);
    @(posedge clk);
    #2;
    reset      = rst;
    out_ready  = rdy;
    core_match = m;
    for (int i = 0; i < N; i++) core_nonce[i*32 +: 32] = $urandom;
  endtask

  initial begin
    reset = 1'b1; out_ready = 1'b0; core_match = '0; core_nonce = '0;
    step('0, 1'b0, 1'b1);
    step('0, 1'b0, 1'b1);
    step('0, 1'b1, 1'b0);

    // Single report from core 2
    step(8'b0000_0100, 1'b1, 1'b0);
    core_nonce[2*32 +: 32] = 32'h4000_1234;
    repeat (4) step('0, 1'b1, 1'b0);

    // Three cores in one cycle
    step(8'b0010_1001, 1'b1, 1'b0);
    repeat (6) step('0, 1'b1, 1'b0);

    // Held report under backpressure
    step(8'b0000_0010, 1'b0, 1'b0);
    repeat (10) step('0, 1'b0, 1'b0);
    repeat (3) step('0, 1'b1, 1'b0);

    // Drops: output busy with core 6, then core 4 twice, then everyone twice
    step(8'b0100_0000, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0);
    step(8'b0001_0000, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0);
    step(8'b0001_0000, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0);
    step(8'hFF, 1'b0, 1'b0);
    step(8'hFF, 1'b0, 1'b0);
    repeat (12) step('0, 1'b1, 1'b0);

    // Fairness between cores 0 and 7
    repeat (20) step(8'b1000_0001, 1'b1, 1'b0);
    repeat (6) step('0, 1'b1, 1'b0);

    // Randomized traffic with occasional reset
    repeat (3000) begin
      step(N'($urandom & $urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 499) == 0));
    end

    // Reset with several slots pending and a report on the output
    step(8'b1010_0100, 1'b0, 1'b0);
    step(8'b0000_0011, 1'b0, 1'b0);
    step('0, 1'b0, 1'b1);
    step('0, 1'b1, 1'b0);
    repeat (20) step('0, 1'b1, 1'b0);

    @(negedge clk);
    #1;
    chk("scoreboard_drained", 64'(exp_core_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
